// File: rtl/upsample_2x2_nearest_stream_if.sv
// Pixel stream bundle for the 2x2 upsampler: valid/ready on the input side,
// valid-only (no backpressure) on the output side.
interface upsample_2x2_nearest_stream_if #(
    parameter int DATA_WIDHT = 32
);
    logic [DATA_WIDHT-1:0] Data_In;
    logic                  Valid_In;
    logic                  Ready_Out;
    logic [DATA_WIDHT-1:0] Data_Out;
    logic                  Valid_Out;
    logic                  Frame_Done;

    modport master (
        output Data_In,
        output Valid_In,
        input  Ready_Out,
        input  Data_Out,
        input  Valid_Out,
        input  Frame_Done
    );

    modport slave (
        input  Data_In,
        input  Valid_In,
        output Ready_Out,
        output Data_Out,
        output Valid_Out,
        output Frame_Done
    );
endinterface

// File: rtl/upsample_2x2_nearest_stream.sv
// Streaming 2x2 nearest-neighbour upsampler: each input pixel is emitted twice on
// the fly, and each completed input row is replayed once from a line buffer.
//
// state  | meaning
// FILL   | accept input row; phase 0 takes a pixel, phase 1 emits its second copy
// REPEAT | replay buffered row, each pixel twice, input throttled
module upsample_2x2_nearest_stream #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDHT  = 15,
    parameter int IMG_HEIGHT = 15
) (
    input  logic clk,
    input  logic rst,
    upsample_2x2_nearest_stream_if.slave s
);
    localparam int COL_W  = (IMG_WIDHT  > 1) ? $clog2(IMG_WIDHT)  : 1;
    localparam int RCNT_W = (2*IMG_WIDHT > 1) ? $clog2(2*IMG_WIDHT) : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDHT - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(2*IMG_WIDHT - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic {
        FILL   = 1'b0,
        REPEAT = 1'b1
    } state_t;

    state_t                state;
    logic                  phase;
    logic [COL_W-1:0]      col;
    logic [RCNT_W-1:0]     rcnt;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDHT-1:0] data_q;
    logic                  valid_q;
    logic                  done_q;

    logic [DATA_WIDHT-1:0] line_buf [IMG_WIDHT];
    logic                  wr_en;
    logic [COL_W-1:0]      rd_idx;
    logic [DATA_WIDHT-1:0] rd_data;

    assign s.Ready_Out  = (state == FILL) && !phase;
    assign s.Data_Out   = data_q;
    assign s.Valid_Out  = valid_q;
    assign s.Frame_Done = done_q;

    assign wr_en   = s.Ready_Out && s.Valid_In;
    // Output pixel index rcnt/2 always fits the column range since rcnt < 2*IMG_WIDHT.
    assign rd_idx  = COL_W'(rcnt >> 1);
    assign rd_data = line_buf[rd_idx];

    // Line buffer keeps no reset; contents are always rewritten before a replay.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[col] <= s.Data_In;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            phase   <= 1'b0;
            col     <= '0;
            rcnt    <= '0;
            row     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                FILL: begin
                    if (!phase) begin
                        if (s.Valid_In) begin
                            data_q  <= s.Data_In;
                            valid_q <= 1'b1;
                            phase   <= 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end else begin
                        valid_q <= 1'b1;
                        phase   <= 1'b0;
                        if (col == COL_LAST) begin
                            col   <= '0;
                            rcnt  <= '0;
                            state <= REPEAT;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    data_q  <= rd_data;
                    valid_q <= 1'b1;
                    if (rcnt == RCNT_LAST) begin
                        state <= FILL;
                        if (row == ROW_LAST) begin
                            row    <= '0;
                            done_q <= 1'b1;
                        end else begin
                            row <= row + ROW_W'(1);
                        end
                    end else begin
                        rcnt <= rcnt + RCNT_W'(1);
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_upsample_2x2_nearest_stream.sv
// Directed bench for the 2x2 upsampler: a 4x2 instance for the main scenarios
// and a 1x1 instance for the degenerate case.
module tb_upsample_2x2_nearest_stream;
    logic clk;
    logic rst;

    upsample_2x2_nearest_stream_if #(.DATA_WIDHT(32)) s0 ();
    upsample_2x2_nearest_stream_if #(.DATA_WIDHT(32)) s1 ();

    upsample_2x2_nearest_stream #(.DATA_WIDHT(32), .IMG_WIDHT(4), .IMG_HEIGHT(2)) dut (
        .clk(clk),
        .rst(rst),
        .s  (s0)
    );

    upsample_2x2_nearest_stream #(.DATA_WIDHT(32), .IMG_WIDHT(1), .IMG_HEIGHT(1)) dut1 (
        .clk(clk),
        .rst(rst),
        .s  (s1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] q_data [$];
    bit          q_fd   [$];
    int          q_cyc  [$];
    bit          q_rdy  [$];
    logic [31:0] q_in   [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change only just after a rising edge, so negedge values are the ones the next edge sees.
    always @(negedge clk) begin
        if (!rst) begin
            cyc = cyc + 1;
            q_rdy.push_back(s0.Ready_Out);
            if (s0.Valid_In && s0.Ready_Out) q_in.push_back(s0.Data_In);
            if (s0.Valid_Out) begin
                q_data.push_back(s0.Data_Out);
                q_fd.push_back(s0.Frame_Done);
                q_cyc.push_back(cyc);
            end
        end
    end

    task automatic clear_capture();
        q_data.delete();
        q_fd.delete();
        q_cyc.delete();
        q_rdy.delete();
        q_in.delete();
    endtask

    task automatic send_pixel(input logic [31:0] d, input int gap);
        int n;
        s0.Valid_In = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        s0.Valid_In = 1'b1;
        s0.Data_In  = d;
        n = 0;
        while (!s0.Ready_Out && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n >= 50) begin
            n_err++;
            $display("FAIL send_timeout: pixel %0h not accepted within %0d cycles", d, n);
        end
        @(posedge clk); #1;
        s0.Valid_In = 1'b0;
    endtask

    task automatic wait_outputs(input int want, input int budget);
        int n;
        n = 0;
        while (q_data.size() < want && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (6) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (q_data.size() != want) begin
            n_err++;
            $display("FAIL out_count: got %0d valid outputs want %0d", q_data.size(), want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s0.Valid_In = 1'b0; s0.Data_In = '0;
        s1.Valid_In = 1'b0; s1.Data_In = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (s0.Data_Out !== 32'h0) begin n_err++; $display("FAIL rst_data: got %0h want 0", s0.Data_Out); end
        n_cmp++; if (s0.Valid_Out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", s0.Valid_Out); end
        n_cmp++; if (s0.Frame_Done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", s0.Frame_Done); end
        n_cmp++; if (s0.Ready_Out !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", s0.Ready_Out); end
        n_cmp++; if (s1.Ready_Out !== 1'b1) begin n_err++; $display("FAIL rst_ready1: got %b want 1", s1.Ready_Out); end
    endtask

    // Expected 4x2 frame with pixels base+1..base+8: row r gives 16 outputs, col c at (k%8)/2.
    task automatic test_basic_frame();
        logic [31:0] exp;
        clear_capture();
        for (int p = 1; p <= 8; p++) send_pixel(p, 0);
        wait_outputs(32, 200);
        for (int i = 0; i < 32 && i < q_data.size(); i++) begin
            exp = 32'((i / 16) * 4 + ((i % 16) % 8) / 2 + 1);
            n_cmp++; if (q_data[i] !== exp) begin n_err++; $display("FAIL basic_data[%0d]: got %0h want %0h", i, q_data[i], exp); end
            n_cmp++; if (q_fd[i] !== (i == 31)) begin n_err++; $display("FAIL basic_done[%0d]: got %b want %b", i, q_fd[i], (i == 31)); end
            n_cmp++; if (q_cyc[i] != q_cyc[0] + i) begin n_err++; $display("FAIL basic_gapless[%0d]: got cycle %0d want %0d", i, q_cyc[i], q_cyc[0] + i); end
        end
    endtask

    task automatic test_ready_pattern();
        bit exp;
        clear_capture();
        for (int p = 1; p <= 8; p++) send_pixel(p, 0);
        wait_outputs(32, 200);
        for (int k = 0; k < 33 && k < q_rdy.size(); k++) begin
            exp = (k >= 32) ? 1'b1 : (((k % 16) < 8) && ((k % 2) == 0));
            n_cmp++; if (q_rdy[k] !== exp) begin n_err++; $display("FAIL ready[%0d]: got %b want %b", k, q_rdy[k], exp); end
        end
        n_cmp++; if (q_in.size() != 8) begin n_err++; $display("FAIL xfer_count: got %0d want 8", q_in.size()); end
        for (int i = 0; i < 8 && i < q_in.size(); i++) begin
            n_cmp++; if (q_in[i] !== 32'(i + 1)) begin n_err++; $display("FAIL xfer[%0d]: got %0h want %0h", i, q_in[i], i + 1); end
        end
    endtask

    // One row A..D with idle gaps: leaves the frame on its second row.
    task automatic test_gaps();
        logic [31:0] pix [4];
        int          gap [4];
        logic [31:0] exp;
        pix[0] = 32'hA; pix[1] = 32'hB; pix[2] = 32'hC; pix[3] = 32'hD;
        gap[0] = 2;     gap[1] = 0;     gap[2] = 3;     gap[3] = 1;
        clear_capture();
        for (int i = 0; i < 4; i++) send_pixel(pix[i], gap[i]);
        wait_outputs(16, 200);
        for (int i = 0; i < 16 && i < q_data.size(); i++) begin
            exp = pix[(i % 8) / 2];
            n_cmp++; if (q_data[i] !== exp) begin n_err++; $display("FAIL gap_data[%0d]: got %0h want %0h", i, q_data[i], exp); end
            n_cmp++; if (q_fd[i] !== 1'b0) begin n_err++; $display("FAIL gap_done[%0d]: got %b want 0", i, q_fd[i]); end
        end
        if (q_cyc.size() >= 16) begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (q_cyc[2*k+1] != q_cyc[2*k] + 1) begin n_err++; $display("FAIL gap_copy[%0d]: got cycle %0d want %0d", k, q_cyc[2*k+1], q_cyc[2*k] + 1); end
            end
            for (int j = 0; j < 8; j++) begin
                n_cmp++; if (q_cyc[8+j] != q_cyc[7] + 1 + j) begin n_err++; $display("FAIL gap_repeat[%0d]: got cycle %0d want %0d", j, q_cyc[8+j], q_cyc[7] + 1 + j); end
            end
            n_cmp++; if (q_cyc[7] - q_cyc[0] != 9) begin n_err++; $display("FAIL gap_bubbles: got span %0d want 9", q_cyc[7] - q_cyc[0]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] exp;
        for (int p = 1; p <= 3; p++) send_pixel(32'h70 + p, 0);
        n_cmp++; if (s0.Valid_Out !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %b want 1", s0.Valid_Out); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (s0.Valid_Out !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", s0.Valid_Out); end
        n_cmp++; if (s0.Data_Out !== 32'h0) begin n_err++; $display("FAIL async_data: got %0h want 0", s0.Data_Out); end
        n_cmp++; if (s0.Frame_Done !== 1'b0) begin n_err++; $display("FAIL async_done: got %b want 0", s0.Frame_Done); end
        n_cmp++; if (s0.Ready_Out !== 1'b1) begin n_err++; $display("FAIL async_ready: got %b want 1", s0.Ready_Out); end
        @(posedge clk); #1 rst = 1'b0;
        clear_capture();
        for (int p = 1; p <= 8; p++) send_pixel(p, 0);
        wait_outputs(32, 200);
        for (int i = 0; i < 32 && i < q_data.size(); i++) begin
            exp = 32'((i / 16) * 4 + ((i % 16) % 8) / 2 + 1);
            n_cmp++; if (q_data[i] !== exp) begin n_err++; $display("FAIL post_rst_data[%0d]: got %0h want %0h", i, q_data[i], exp); end
            n_cmp++; if (q_fd[i] !== (i == 31)) begin n_err++; $display("FAIL post_rst_done[%0d]: got %b want %b", i, q_fd[i], (i == 31)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        clear_capture();
        for (int p = 1; p <= 16; p++) send_pixel(p, 0);
        wait_outputs(64, 300);
        for (int i = 0; i < 64 && i < q_data.size(); i++) begin
            exp = 32'((i / 32) * 8 + ((i % 32) / 16) * 4 + ((i % 16) % 8) / 2 + 1);
            n_cmp++; if (q_data[i] !== exp) begin n_err++; $display("FAIL b2b_data[%0d]: got %0h want %0h", i, q_data[i], exp); end
            n_cmp++; if (q_fd[i] !== (i == 31 || i == 63)) begin n_err++; $display("FAIL b2b_done[%0d]: got %b want %b", i, q_fd[i], (i == 31 || i == 63)); end
        end
        if (q_cyc.size() >= 33) begin
            n_cmp++; if (q_cyc[32] != q_cyc[31] + 1) begin n_err++; $display("FAIL b2b_restart: got cycle %0d want %0d", q_cyc[32], q_cyc[31] + 1); end
        end
    endtask

    task automatic test_degenerate();
        s1.Data_In  = 32'h55;
        s1.Valid_In = 1'b1;
        n_cmp++; if (s1.Ready_Out !== 1'b1) begin n_err++; $display("FAIL deg_ready_in: got %b want 1", s1.Ready_Out); end
        @(posedge clk); #1;
        s1.Valid_In = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (s1.Valid_Out !== 1'b1) begin n_err++; $display("FAIL deg_valid[%0d]: got %b want 1", i, s1.Valid_Out); end
            n_cmp++; if (s1.Data_Out !== 32'h55) begin n_err++; $display("FAIL deg_data[%0d]: got %0h want 55", i, s1.Data_Out); end
            n_cmp++; if (s1.Frame_Done !== (i == 3)) begin n_err++; $display("FAIL deg_done[%0d]: got %b want %b", i, s1.Frame_Done, (i == 3)); end
            n_cmp++; if (s1.Ready_Out !== (i == 3)) begin n_err++; $display("FAIL deg_ready[%0d]: got %b want %b", i, s1.Ready_Out, (i == 3)); end
            @(posedge clk); #1;
        end
        n_cmp++; if (s1.Valid_Out !== 1'b0) begin n_err++; $display("FAIL deg_idle_valid: got %b want 0", s1.Valid_Out); end
        n_cmp++; if (s1.Frame_Done !== 1'b0) begin n_err++; $display("FAIL deg_idle_done: got %b want 0", s1.Frame_Done); end
        n_cmp++; if (s1.Ready_Out !== 1'b1) begin n_err++; $display("FAIL deg_idle_ready: got %b want 1", s1.Ready_Out); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic_frame();
        test_ready_pattern();
        test_gaps();
        test_reset_mid_frame();
        test_back_to_back();
        test_degenerate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
